// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, with a small byte FIFO behind a valid/ready handshake.
// The tx line is always driven from a flop, so it stays glitch-free.
module uart_transmitter #(
    parameter int clock_frequency = 25000000,
    parameter int baud_rate       = 115200,
    parameter int fifo_depth      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx,
    output logic       busy
);

    localparam int clock_cycles_in_symbol = clock_frequency / baud_rate;
    localparam int addr_w = $clog2(fifo_depth);
    localparam int ptr_w  = addr_w + 1;
    localparam logic [31:0] symbol_reload = 32'(clock_cycles_in_symbol - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_reg;
    logic [7:0]       fifo_mem [fifo_depth];
    logic [ptr_w-1:0] wr_ptr_reg;
    logic [ptr_w-1:0] rd_ptr_reg;
    logic [7:0]       shift_reg;
    logic [31:0]      symbol_count_reg;
    logic [2:0]       bit_index_reg;
    logic             tx_reg;

    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic [7:0]       fifo_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[ptr_w-1] != rd_ptr_reg[ptr_w-1]) &&
                        (wr_ptr_reg[addr_w-1:0] == rd_ptr_reg[addr_w-1:0]);
    assign byte_ready = !fifo_full;
    assign push       = byte_valid && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr_reg[addr_w-1:0]];

    assign tx   = tx_reg;
    assign busy = (state_reg != IDLE) || !fifo_empty;

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr_reg[addr_w-1:0]] <= byte_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            tx_reg           <= 1'b1;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            shift_reg        <= '0;
            symbol_count_reg <= '0;
            bit_index_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
            end

            if (state_reg != IDLE && symbol_count_reg != 32'd0) begin
                symbol_count_reg <= symbol_count_reg - 32'd1;
            end

            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg        <= fifo_head;
                        rd_ptr_reg       <= rd_ptr_reg + ptr_w'(1);
                        symbol_count_reg <= symbol_reload;
                        tx_reg           <= 1'b0;
                        state_reg        <= START;
                    end
                end
                START: begin
                    if (symbol_count_reg == 32'd0) begin
                        tx_reg           <= shift_reg[0];
                        symbol_count_reg <= symbol_reload;
                        bit_index_reg    <= 3'd0;
                        state_reg        <= DATA;
                    end
                end
                DATA: begin
                    if (symbol_count_reg == 32'd0) begin
                        symbol_count_reg <= symbol_reload;
                        if (bit_index_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            shift_reg     <= shift_reg >> 1;
                            tx_reg        <= shift_reg[1];
                            bit_index_reg <= bit_index_reg + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (symbol_count_reg == 32'd0) begin
                        // Chain straight into the next start bit so bursts have no idle gap.
                        if (!fifo_empty) begin
                            shift_reg        <= fifo_head;
                            rd_ptr_reg       <= rd_ptr_reg + ptr_w'(1);
                            symbol_count_reg <= symbol_reload;
                            tx_reg           <= 1'b0;
                            state_reg        <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
